// File: rtl/decode_byte_queue_pkg.sv
// Shared decode-side types and sizing constants for the byte queue and its window.
package decode_byte_queue_pkg;

    localparam int DECODE_WINDOW_BYTES = 8;
    localparam int FETCH_BYTES         = 4;

    typedef logic [7:0] code_byte_t;
    typedef code_byte_t decode_window_t [0:DECODE_WINDOW_BYTES-1];

endpackage

// File: rtl/decode_byte_rotator.sv
// Selects WINDOW consecutive bytes of the circular buffer starting at the read
// pointer; bytes at or beyond the current fill level are forced to zero.
module decode_byte_rotator #(
    parameter int DEPTH  = 16,
    parameter int WINDOW = 8
) (
    input  logic [7:0]                 i_mem [0:DEPTH-1],
    input  logic [$clog2(DEPTH)-1:0]   i_rd_ptr,
    input  logic [$clog2(DEPTH):0]     i_count,
    output logic [7:0]                 o_window [0:WINDOW-1]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    genvar gi;
    generate
        for (gi = 0; gi < WINDOW; gi++) begin : g_lane
            // Index wraps naturally because it is kept at pointer width.
            logic [PW-1:0] w_idx;
            assign w_idx         = i_rd_ptr + PW'(gi);
            assign o_window[gi]  = (CW'(gi) < i_count) ? i_mem[w_idx] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/decode_byte_queue.sv
// Byte-granular instruction queue between prefetch and decode. Holds the
// circular buffer, read/write pointers, fill count and the underflow flag;
// the window itself is produced by decode_byte_rotator.
module decode_byte_queue #(
    parameter int DEPTH       = 16,
    parameter int FETCH_BYTES = 4,
    parameter int WINDOW      = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_flush,
    input  logic                       i_fetch_valid,
    input  logic [8*FETCH_BYTES-1:0]   i_fetch_data,
    input  logic [2:0]                 i_fetch_count,
    output logic                       o_fetch_ready,
    output logic [7:0]                 o_window [0:WINDOW-1],
    output logic [$clog2(DEPTH):0]     o_window_count,
    input  logic                       i_consume_valid,
    input  logic [3:0]                 i_consume_bytes,
    output logic                       o_underflow
);

    import decode_byte_queue_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = PW + 2;

    code_byte_t    r_mem [0:DEPTH-1];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_underflow;

    logic [AW-1:0] w_count_ext;
    logic          w_fetch_ready;
    logic          w_fetch_count_ok;
    logic          w_push;
    logic [AW-1:0] w_push_n;
    logic          w_consume_legal;
    logic          w_consume_illegal;
    logic [AW-1:0] w_consume_n;
    logic [AW-1:0] w_count_sum;

    // Ready is judged on the pre-update count, so a worst-case push always fits.
    assign w_count_ext       = AW'(r_count);
    assign w_fetch_ready     = (AW'(DEPTH) - w_count_ext) >= AW'(FETCH_BYTES);
    assign w_fetch_count_ok  = (i_fetch_count != 3'd0) && (AW'(i_fetch_count) <= AW'(FETCH_BYTES));
    assign w_push            = i_fetch_valid && w_fetch_ready && w_fetch_count_ok;
    assign w_push_n          = w_push ? AW'(i_fetch_count) : '0;
    assign w_consume_legal   = i_consume_valid && (AW'(i_consume_bytes) <= w_count_ext);
    assign w_consume_illegal = i_consume_valid && !w_consume_legal;
    assign w_consume_n       = w_consume_legal ? AW'(i_consume_bytes) : '0;
    assign w_count_sum       = w_count_ext + w_push_n - w_consume_n;

    // Pointer, count and underflow state; flush outranks push and consume.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(i_fetch_count);
            end
            if (w_consume_legal) begin
                r_rd_ptr <= r_rd_ptr + PW'(i_consume_bytes);
            end
            r_count     <= CW'(w_count_sum);
            r_underflow <= w_consume_illegal;
        end
    end

    // Byte storage is never cleared; the window masks anything beyond count.
    always_ff @(posedge i_clock) begin
        for (int k = 0; k < FETCH_BYTES; k++) begin
            if (w_push && !i_flush && (3'(k) < i_fetch_count)) begin
                r_mem[r_wr_ptr + PW'(k)] <= i_fetch_data[8*k +: 8];
            end
        end
    end

    // Simulation-only sanity checks on occupancy and push acceptance.
    always_ff @(posedge i_clock) begin
        if (i_reset_n) begin
            assert (w_count_ext <= AW'(DEPTH));
            assert (!(w_push && !w_fetch_ready));
        end
    end

    decode_byte_rotator #(
        .DEPTH  (DEPTH),
        .WINDOW (WINDOW)
    ) u_rotator (
        .i_mem    (r_mem),
        .i_rd_ptr (r_rd_ptr),
        .i_count  (r_count),
        .o_window (o_window)
    );

    assign o_fetch_ready  = w_fetch_ready;
    assign o_window_count = r_count;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_decode_byte_queue.sv
// Directed bench for decode_byte_queue: hand-computed expectations, one line per check on failure.
module tb_decode_byte_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic [2:0]  fetch_count;
    logic        fetch_ready;
    logic [7:0]  win [0:7];
    logic [4:0]  win_count;
    logic        consume_valid;
    logic [3:0]  consume_bytes;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    decode_byte_queue dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_flush         (flush),
        .i_fetch_valid   (fetch_valid),
        .i_fetch_data    (fetch_data),
        .i_fetch_count   (fetch_count),
        .o_fetch_ready   (fetch_ready),
        .o_window        (win),
        .o_window_count  (win_count),
        .i_consume_valid (consume_valid),
        .i_consume_bytes (consume_bytes),
        .o_underflow     (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [63:0] exp);
        logic [63:0] obs;
        for (int k = 0; k < 8; k++) obs[8*k +: 8] = win[k];
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s window observed=%016h expected=%016h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [31:0] fd, input logic [2:0] fc,
                         input logic cv, input logic [3:0] cb);
        flush         = fl;
        fetch_valid   = fv;
        fetch_data    = fd;
        fetch_count   = fc;
        consume_valid = cv;
        consume_bytes = cb;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 3'd0, 0, 4'd0);
        #3;
        chk("reset_ready", 32'(fetch_ready), 32'd1);
        chk("reset_count", 32'(win_count), 32'd0);
        chk("reset_underflow", 32'(underflow), 32'd0);
        chk_win("reset_window", 64'h0);
        #4 rst_n = 1'b1;

        // first push, 1-cycle latency
        drive(0, 1, 32'h44332211, 3'd4, 0, 4'd0); cyc();
        chk("push1_count", 32'(win_count), 32'd4);
        chk("push1_ready", 32'(fetch_ready), 32'd1);
        chk_win("push1_window", 64'h00000000_44332211);

        // fetch_count 0 and 5 are no-ops
        drive(0, 1, 32'hffffffff, 3'd0, 0, 4'd0); cyc();
        chk("cnt0_count", 32'(win_count), 32'd4);
        drive(0, 1, 32'hffffffff, 3'd5, 0, 4'd0); cyc();
        chk("cnt5_count", 32'(win_count), 32'd4);
        chk_win("cnt5_window", 64'h00000000_44332211);

        // fill to 16
        drive(0, 1, 32'h88776655, 3'd4, 0, 4'd0); cyc();
        chk("fill8_count", 32'(win_count), 32'd8);
        chk_win("fill8_window", 64'h88776655_44332211);
        drive(0, 1, 32'hccbbaa99, 3'd4, 0, 4'd0); cyc();
        chk("fill12_count", 32'(win_count), 32'd12);
        chk("fill12_ready", 32'(fetch_ready), 32'd1);
        drive(0, 1, 32'h10ffeedd, 3'd4, 0, 4'd0); cyc();
        chk("fill16_count", 32'(win_count), 32'd16);
        chk("fill16_ready", 32'(fetch_ready), 32'd0);
        drive(0, 1, 32'hdeadbeef, 3'd4, 0, 4'd0); cyc();
        chk("drop_count", 32'(win_count), 32'd16);
        chk_win("drop_window", 64'h88776655_44332211);

        // drain toward rd_ptr=14
        drive(0, 0, 32'h0, 3'd0, 1, 4'd8); cyc();
        chk("cons8_count", 32'(win_count), 32'd8);
        chk("cons8_ready", 32'(fetch_ready), 32'd1);
        chk_win("cons8_window", 64'h10ffeedd_ccbbaa99);
        drive(0, 0, 32'h0, 3'd0, 1, 4'd6); cyc();
        chk("cons6_count", 32'(win_count), 32'd2);
        chk_win("cons6_window", 64'h00000000_000010ff);

        // refill to 12 with rd_ptr=14
        drive(0, 1, 32'ha3a2a1a0, 3'd4, 0, 4'd0); cyc();
        drive(0, 1, 32'hb3b2b1b0, 3'd4, 0, 4'd0); cyc();
        drive(0, 1, 32'h0000c1c0, 3'd2, 0, 4'd0); cyc();
        chk("wrap_pre_count", 32'(win_count), 32'd12);
        chk_win("wrap_pre_window", 64'hb1b0a3a2_a1a010ff);

        // simultaneous consume 6 + push 4 across the wrap
        drive(0, 1, 32'hd3d2d1d0, 3'd4, 1, 4'd6); cyc();
        chk("wrap_count", 32'(win_count), 32'd10);
        chk_win("wrap_window", 64'hd1d0c1c0_b3b2b1b0);
        chk("wrap_underflow", 32'(underflow), 32'd0);

        // consume of zero bytes is a legal no-op
        drive(0, 0, 32'h0, 3'd0, 1, 4'd0); cyc();
        chk("cons0_count", 32'(win_count), 32'd10);
        chk("cons0_underflow", 32'(underflow), 32'd0);

        // down to 3, then illegal consume 5 with push 2
        drive(0, 0, 32'h0, 3'd0, 1, 4'd7); cyc();
        chk("cons7_count", 32'(win_count), 32'd3);
        chk_win("cons7_window", 64'h00000000_00d3d2d1);
        drive(0, 1, 32'h0000e1e0, 3'd2, 1, 4'd5); cyc();
        chk("under_flag", 32'(underflow), 32'd1);
        chk("under_count", 32'(win_count), 32'd5);
        chk_win("under_window", 64'h000000e1_e0d3d2d1);
        drive(0, 0, 32'h0, 3'd0, 0, 4'd0); cyc();
        chk("under_pulse_end", 32'(underflow), 32'd0);
        chk("under_idle_count", 32'(win_count), 32'd5);

        // flush beats push and an illegal consume
        drive(1, 1, 32'h77777777, 3'd4, 1, 4'd9); cyc();
        chk("flush_count", 32'(win_count), 32'd0);
        chk("flush_ready", 32'(fetch_ready), 32'd1);
        chk("flush_underflow", 32'(underflow), 32'd0);
        chk_win("flush_window", 64'h0);
        drive(0, 0, 32'h0, 3'd0, 0, 4'd0); cyc();
        chk("flush_idle_underflow", 32'(underflow), 32'd0);
        chk("flush_idle_count", 32'(win_count), 32'd0);

        // build count=9 with underflow pending, then async reset
        drive(0, 1, 32'h04030201, 3'd4, 0, 4'd0); cyc();
        drive(0, 1, 32'h08070605, 3'd4, 0, 4'd0); cyc();
        drive(0, 1, 32'h00000009, 3'd1, 0, 4'd0); cyc();
        chk("pre_rst_count", 32'(win_count), 32'd9);
        chk_win("pre_rst_window", 64'h08070605_04030201);
        drive(0, 0, 32'h0, 3'd0, 1, 4'd15); cyc();
        chk("pre_rst_underflow", 32'(underflow), 32'd1);
        chk("pre_rst_count2", 32'(win_count), 32'd9);
        drive(0, 0, 32'h0, 3'd0, 0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(win_count), 32'd0);
        chk("async_rst_ready", 32'(fetch_ready), 32'd1);
        chk("async_rst_underflow", 32'(underflow), 32'd0);
        chk_win("async_rst_window", 64'h0);
        #2 rst_n = 1'b1;
        drive(0, 1, 32'h0000005a, 3'd1, 0, 4'd0); cyc();
        chk("post_rst_count", 32'(win_count), 32'd1);
        chk_win("post_rst_window", 64'h00000000_0000005a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
